// File: rtl/tcpc_transmit_scheduler_if.sv
// Transmit-path handshake bundle between the TCPC register/PHY environment
// (master side) and the transmit scheduler (slave side).
interface tcpc_transmit_scheduler_if;
  logic       transmit_wr;
  logic [7:0] TRANSMIT;
  logic       rx_busy;
  logic       msg_done;
  logic       msg_goodcrc;
  logic       hr_success;
  logic       hr_failed;
  logic       msg_start;
  logic       msg_abort;
  logic [2:0] msg_sop_type;
  logic       hr_hard_reset_L;
  logic       hr_cable_reset_L;
  logic       ALERT_TransmitSuccessful;
  logic       ALERT_TransmitSOPMessageFailed;
  logic       ALERT_TransmitSOPMessageDiscarded;
  logic       busy;

  modport master (
    output transmit_wr, TRANSMIT, rx_busy, msg_done, msg_goodcrc, hr_success, hr_failed,
    input  msg_start, msg_abort, msg_sop_type, hr_hard_reset_L, hr_cable_reset_L,
           ALERT_TransmitSuccessful, ALERT_TransmitSOPMessageFailed,
           ALERT_TransmitSOPMessageDiscarded, busy
  );

  modport slave (
    input  transmit_wr, TRANSMIT, rx_busy, msg_done, msg_goodcrc, hr_success, hr_failed,
    output msg_start, msg_abort, msg_sop_type, hr_hard_reset_L, hr_cable_reset_L,
           ALERT_TransmitSuccessful, ALERT_TransmitSOPMessageFailed,
           ALERT_TransmitSOPMessageDiscarded, busy
  );
endinterface

// File: rtl/tcpc_transmit_scheduler.sv
// TCPC transmit scheduler: decodes TRANSMIT writes, runs SOP* message attempts
// with GoodCRC retries and a watchdog, issues hard/cable reset requests, lets a
// reset preempt an in-flight message, and reports outcomes as ALERT pulses.
// Every output is a flop; its next value is derived from the next state.
module tcpc_transmit_scheduler #(
  parameter int          MAX_RETRY   = 3,
  parameter logic [15:0] MSG_TIMEOUT = 16'd1000
) (
  input  logic                         clk,
  input  logic                         reset_L,
  tcpc_transmit_scheduler_if.slave     tx
);

  typedef enum logic [2:0] {IDLE, MSG_START, MSG_WAIT, HR_START, HR_WAIT} state_t;

  localparam logic [1:0] RETRY_CAP = (MAX_RETRY >= 3) ? 2'd3 : 2'(MAX_RETRY);
  localparam logic [2:0] T_HARD    = 3'b101;
  localparam logic [2:0] T_CABLE   = 3'b110;
  localparam logic [2:0] T_BIST    = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  retries_q, retries_d;
  logic [15:0] wdog_q, wdog_d;
  logic        msg_start_q, msg_start_d;
  logic        abort_q, abort_d;
  logic        hard_q, hard_d;
  logic        cable_q, cable_d;
  logic        succ_q, succ_d;
  logic        fail_q, fail_d;
  logic        disc_q, disc_d;
  logic        busy_q, busy_d;

  logic        hr_wr;
  logic        attempt_fail;
  logic [1:0]  req_retries;

  // Next-state, retry/watchdog bookkeeping and registered-output values.
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    retries_d    = retries_q;
    wdog_d       = wdog_q;
    abort_d      = 1'b0;
    succ_d       = 1'b0;
    fail_d       = 1'b0;
    disc_d       = 1'b0;
    attempt_fail = 1'b0;
    hr_wr        = tx.transmit_wr &&
                   (tx.TRANSMIT[2:0] == T_HARD || tx.TRANSMIT[2:0] == T_CABLE);
    req_retries  = (tx.TRANSMIT[5:4] > RETRY_CAP) ? RETRY_CAP : tx.TRANSMIT[5:4];

    case (state_q)
      IDLE: begin
        if (tx.transmit_wr) begin
          type_d    = tx.TRANSMIT[2:0];
          retries_d = req_retries;
          if (hr_wr)            state_d = HR_START;
          else if (tx.rx_busy)  disc_d  = 1'b1;
          else                  state_d = MSG_START;
        end
      end
      MSG_START, MSG_WAIT: begin
        if (hr_wr) begin
          // A reset request wins over anything the message path reports.
          abort_d   = 1'b1;
          disc_d    = 1'b1;
          type_d    = tx.TRANSMIT[2:0];
          retries_d = req_retries;
          state_d   = HR_START;
        end else begin
          disc_d = tx.transmit_wr;
          if (state_q == MSG_START) begin
            wdog_d  = MSG_TIMEOUT;
            state_d = MSG_WAIT;
          end else begin
            wdog_d = (wdog_q == 16'd0) ? 16'd0 : wdog_q - 16'd1;
            if (tx.msg_done) begin
              if (tx.msg_goodcrc || type_q == T_BIST) begin
                succ_d  = 1'b1;
                state_d = IDLE;
              end else begin
                attempt_fail = 1'b1;
              end
            end else if (wdog_q <= 16'd1) begin
              // Watchdog reaches zero this cycle: give up on the attempt.
              attempt_fail = 1'b1;
              abort_d      = 1'b1;
            end
            if (attempt_fail) begin
              if (retries_q != 2'd0) begin
                retries_d = retries_q - 2'd1;
                state_d   = MSG_START;
              end else begin
                fail_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
      end
      HR_START: begin
        disc_d  = tx.transmit_wr;
        state_d = HR_WAIT;
      end
      HR_WAIT: begin
        disc_d = tx.transmit_wr;
        if (tx.hr_success) begin
          succ_d  = 1'b1;
          state_d = IDLE;
        end else if (tx.hr_failed) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    msg_start_d = (state_d == MSG_START);
    hard_d      = !(state_d == HR_START && type_d == T_HARD);
    cable_d     = !(state_d == HR_START && type_d == T_CABLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset drops any command without an ALERT.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      type_q      <= 3'b000;
      retries_q   <= 2'd0;
      wdog_q      <= 16'd0;
      msg_start_q <= 1'b0;
      abort_q     <= 1'b0;
      hard_q      <= 1'b1;
      cable_q     <= 1'b1;
      succ_q      <= 1'b0;
      fail_q      <= 1'b0;
      disc_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      retries_q   <= retries_d;
      wdog_q      <= wdog_d;
      msg_start_q <= msg_start_d;
      abort_q     <= abort_d;
      hard_q      <= hard_d;
      cable_q     <= cable_d;
      succ_q      <= succ_d;
      fail_q      <= fail_d;
      disc_q      <= disc_d;
      busy_q      <= busy_d;
    end
  end

  assign tx.msg_start                         = msg_start_q;
  assign tx.msg_abort                         = abort_q;
  assign tx.msg_sop_type                      = type_q;
  assign tx.hr_hard_reset_L                   = hard_q;
  assign tx.hr_cable_reset_L                  = cable_q;
  assign tx.ALERT_TransmitSuccessful          = succ_q;
  assign tx.ALERT_TransmitSOPMessageFailed    = fail_q;
  assign tx.ALERT_TransmitSOPMessageDiscarded = disc_q;
  assign tx.busy                              = busy_q;

endmodule

// File: tb/tb_tcpc_transmit_scheduler.sv
// Directed testbench for tcpc_transmit_scheduler (MSG_TIMEOUT = 16).
module tb_tcpc_transmit_scheduler;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int total = 0;
  int bad = 0;
  int n_start = 0, n_abort = 0, n_succ = 0, n_fail = 0, n_disc = 0, n_hard = 0, n_cable = 0;

  tcpc_transmit_scheduler_if tx();

  tcpc_transmit_scheduler #(.MAX_RETRY(3), .MSG_TIMEOUT(16'd16)) dut (
    .clk(clk), .reset_L(reset_L), .tx(tx)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx.msg_start) n_start++;
    if (tx.msg_abort) n_abort++;
    if (tx.ALERT_TransmitSuccessful) n_succ++;
    if (tx.ALERT_TransmitSOPMessageFailed) n_fail++;
    if (tx.ALERT_TransmitSOPMessageDiscarded) n_disc++;
    if (!tx.hr_hard_reset_L) n_hard++;
    if (!tx.hr_cable_reset_L) n_cable++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [7:0] v);
    tx.transmit_wr = 1'b1;
    tx.TRANSMIT    = v;
    tick();
    tx.transmit_wr = 1'b0;
    tx.TRANSMIT    = 8'h00;
  endtask

  task automatic pulse_done(input logic crc);
    tx.msg_done    = 1'b1;
    tx.msg_goodcrc = crc;
    tick();
    tx.msg_done    = 1'b0;
    tx.msg_goodcrc = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if (tx.msg_start !== 1'b0) begin bad++; $display("FAIL rst_msg_start got=%b want=0", tx.msg_start); end
    total++; if (tx.msg_abort !== 1'b0) begin bad++; $display("FAIL rst_msg_abort got=%b want=0", tx.msg_abort); end
    total++; if (tx.msg_sop_type !== 3'b000) begin bad++; $display("FAIL rst_sop_type got=%b want=000", tx.msg_sop_type); end
    total++; if (tx.hr_hard_reset_L !== 1'b1) begin bad++; $display("FAIL rst_hard got=%b want=1", tx.hr_hard_reset_L); end
    total++; if (tx.hr_cable_reset_L !== 1'b1) begin bad++; $display("FAIL rst_cable got=%b want=1", tx.hr_cable_reset_L); end
    total++; if (tx.ALERT_TransmitSuccessful !== 1'b0) begin bad++; $display("FAIL rst_succ got=%b want=0", tx.ALERT_TransmitSuccessful); end
    total++; if (tx.ALERT_TransmitSOPMessageFailed !== 1'b0) begin bad++; $display("FAIL rst_fail got=%b want=0", tx.ALERT_TransmitSOPMessageFailed); end
    total++; if (tx.ALERT_TransmitSOPMessageDiscarded !== 1'b0) begin bad++; $display("FAIL rst_disc got=%b want=0", tx.ALERT_TransmitSOPMessageDiscarded); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", tx.busy); end
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_retry_success();
    int s_start = n_start, s_succ = n_succ, s_fail = n_fail;
    drive_wr(8'h30);
    total++; if (tx.msg_start !== 1'b1) begin bad++; $display("FAIL rs_first_start got=%b want=1", tx.msg_start); end
    total++; if (tx.busy !== 1'b1) begin bad++; $display("FAIL rs_busy_rise got=%b want=1", tx.busy); end
    for (int a = 0; a < 4; a++) begin
      tick();
      tick();
      pulse_done(a == 3);
      if (a < 3) begin
        total++; if (tx.msg_start !== 1'b1) begin bad++; $display("FAIL rs_retry_start[%0d] got=%b want=1", a, tx.msg_start); end
      end else begin
        total++; if (tx.ALERT_TransmitSuccessful !== 1'b1) begin bad++; $display("FAIL rs_succ got=%b want=1", tx.ALERT_TransmitSuccessful); end
        total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL rs_busy_fall got=%b want=0", tx.busy); end
      end
    end
    tick();
    total++; if (n_start - s_start !== 4) begin bad++; $display("FAIL rs_start_count got=%0d want=4", n_start - s_start); end
    total++; if (n_succ - s_succ !== 1) begin bad++; $display("FAIL rs_succ_count got=%0d want=1", n_succ - s_succ); end
    total++; if (n_fail - s_fail !== 0) begin bad++; $display("FAIL rs_fail_count got=%0d want=0", n_fail - s_fail); end
  endtask

  task automatic test_retry_fail();
    int s_start = n_start, s_succ = n_succ, s_fail = n_fail;
    drive_wr(8'h10);
    for (int a = 0; a < 2; a++) begin
      tick();
      tick();
      pulse_done(1'b0);
    end
    total++; if (tx.ALERT_TransmitSOPMessageFailed !== 1'b1) begin bad++; $display("FAIL rf_fail got=%b want=1", tx.ALERT_TransmitSOPMessageFailed); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL rf_busy got=%b want=0", tx.busy); end
    total++; if (tx.msg_start !== 1'b0) begin bad++; $display("FAIL rf_no_third_start got=%b want=0", tx.msg_start); end
    tick();
    total++; if (n_start - s_start !== 2) begin bad++; $display("FAIL rf_start_count got=%0d want=2", n_start - s_start); end
    total++; if (n_fail - s_fail !== 1) begin bad++; $display("FAIL rf_fail_count got=%0d want=1", n_fail - s_fail); end
    total++; if (n_succ - s_succ !== 0) begin bad++; $display("FAIL rf_succ_count got=%0d want=0", n_succ - s_succ); end
  endtask

  task automatic test_watchdog();
    int s_start = n_start, s_abort = n_abort;
    drive_wr(8'h00);
    repeat (16) tick();
    total++; if (tx.msg_abort !== 1'b0) begin bad++; $display("FAIL wd_early_abort got=%b want=0", tx.msg_abort); end
    total++; if (tx.busy !== 1'b1) begin bad++; $display("FAIL wd_busy_hold got=%b want=1", tx.busy); end
    tick();
    total++; if (tx.msg_abort !== 1'b1) begin bad++; $display("FAIL wd_abort got=%b want=1", tx.msg_abort); end
    total++; if (tx.ALERT_TransmitSOPMessageFailed !== 1'b1) begin bad++; $display("FAIL wd_fail got=%b want=1", tx.ALERT_TransmitSOPMessageFailed); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL wd_busy got=%b want=0", tx.busy); end
    tick();
    total++; if (n_abort - s_abort !== 1) begin bad++; $display("FAIL wd_abort_count got=%0d want=1", n_abort - s_abort); end
    total++; if (n_start - s_start !== 1) begin bad++; $display("FAIL wd_start_count got=%0d want=1", n_start - s_start); end
  endtask

  task automatic test_preempt();
    int s_start = n_start, s_succ = n_succ, s_hard = n_hard;
    drive_wr(8'h00);
    tick();
    tx.msg_done = 1'b1; tx.msg_goodcrc = 1'b1;
    tx.transmit_wr = 1'b1; tx.TRANSMIT = 8'h05;
    tick();
    tx.msg_done = 1'b0; tx.msg_goodcrc = 1'b0;
    tx.transmit_wr = 1'b0; tx.TRANSMIT = 8'h00;
    total++; if (tx.msg_abort !== 1'b1) begin bad++; $display("FAIL pe_abort got=%b want=1", tx.msg_abort); end
    total++; if (tx.ALERT_TransmitSOPMessageDiscarded !== 1'b1) begin bad++; $display("FAIL pe_disc got=%b want=1", tx.ALERT_TransmitSOPMessageDiscarded); end
    total++; if (tx.ALERT_TransmitSuccessful !== 1'b0) begin bad++; $display("FAIL pe_no_succ got=%b want=0", tx.ALERT_TransmitSuccessful); end
    total++; if (tx.hr_hard_reset_L !== 1'b0) begin bad++; $display("FAIL pe_hard got=%b want=0", tx.hr_hard_reset_L); end
    total++; if (tx.hr_cable_reset_L !== 1'b1) begin bad++; $display("FAIL pe_cable got=%b want=1", tx.hr_cable_reset_L); end
    total++; if (tx.msg_sop_type !== 3'b101) begin bad++; $display("FAIL pe_type got=%b want=101", tx.msg_sop_type); end
    tick();
    total++; if (tx.hr_hard_reset_L !== 1'b1) begin bad++; $display("FAIL pe_hard_release got=%b want=1", tx.hr_hard_reset_L); end
    total++; if (tx.busy !== 1'b1) begin bad++; $display("FAIL pe_busy got=%b want=1", tx.busy); end
    tx.hr_success = 1'b1; tx.hr_failed = 1'b1;
    tick();
    tx.hr_success = 1'b0; tx.hr_failed = 1'b0;
    total++; if (tx.ALERT_TransmitSuccessful !== 1'b1) begin bad++; $display("FAIL pe_hr_succ got=%b want=1", tx.ALERT_TransmitSuccessful); end
    total++; if (tx.ALERT_TransmitSOPMessageFailed !== 1'b0) begin bad++; $display("FAIL pe_hr_nofail got=%b want=0", tx.ALERT_TransmitSOPMessageFailed); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL pe_busy_fall got=%b want=0", tx.busy); end
    tick();
    total++; if (n_succ - s_succ !== 1) begin bad++; $display("FAIL pe_succ_count got=%0d want=1", n_succ - s_succ); end
    total++; if (n_hard - s_hard !== 1) begin bad++; $display("FAIL pe_hard_count got=%0d want=1", n_hard - s_hard); end
    total++; if (n_start - s_start !== 1) begin bad++; $display("FAIL pe_start_count got=%0d want=1", n_start - s_start); end
  endtask

  task automatic test_cable_fail();
    int s_start = n_start, s_cable = n_cable, s_disc = n_disc, s_hard = n_hard;
    drive_wr(8'h06);
    total++; if (tx.hr_cable_reset_L !== 1'b0) begin bad++; $display("FAIL cf_cable got=%b want=0", tx.hr_cable_reset_L); end
    total++; if (tx.hr_hard_reset_L !== 1'b1) begin bad++; $display("FAIL cf_hard got=%b want=1", tx.hr_hard_reset_L); end
    total++; if (tx.busy !== 1'b1) begin bad++; $display("FAIL cf_busy got=%b want=1", tx.busy); end
    repeat (6) tick();
    drive_wr(8'h00);
    total++; if (tx.ALERT_TransmitSOPMessageDiscarded !== 1'b1) begin bad++; $display("FAIL cf_disc got=%b want=1", tx.ALERT_TransmitSOPMessageDiscarded); end
    total++; if (tx.msg_start !== 1'b0) begin bad++; $display("FAIL cf_no_start got=%b want=0", tx.msg_start); end
    total++; if (tx.busy !== 1'b1) begin bad++; $display("FAIL cf_busy_hold got=%b want=1", tx.busy); end
    repeat (43) tick();
    tx.hr_failed = 1'b1;
    tick();
    tx.hr_failed = 1'b0;
    total++; if (tx.ALERT_TransmitSOPMessageFailed !== 1'b1) begin bad++; $display("FAIL cf_fail got=%b want=1", tx.ALERT_TransmitSOPMessageFailed); end
    total++; if (tx.ALERT_TransmitSuccessful !== 1'b0) begin bad++; $display("FAIL cf_no_succ got=%b want=0", tx.ALERT_TransmitSuccessful); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL cf_busy_fall got=%b want=0", tx.busy); end
    tick();
    total++; if (n_cable - s_cable !== 1) begin bad++; $display("FAIL cf_cable_count got=%0d want=1", n_cable - s_cable); end
    total++; if (n_hard - s_hard !== 0) begin bad++; $display("FAIL cf_hard_count got=%0d want=0", n_hard - s_hard); end
    total++; if (n_disc - s_disc !== 1) begin bad++; $display("FAIL cf_disc_count got=%0d want=1", n_disc - s_disc); end
    total++; if (n_start - s_start !== 0) begin bad++; $display("FAIL cf_start_count got=%0d want=0", n_start - s_start); end
  endtask

  task automatic test_rx_busy();
    int s_start = n_start;
    tx.rx_busy = 1'b1;
    drive_wr(8'h01);
    total++; if (tx.ALERT_TransmitSOPMessageDiscarded !== 1'b1) begin bad++; $display("FAIL rx_disc got=%b want=1", tx.ALERT_TransmitSOPMessageDiscarded); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL rx_busy_out got=%b want=0", tx.busy); end
    total++; if (tx.msg_start !== 1'b0) begin bad++; $display("FAIL rx_no_start got=%b want=0", tx.msg_start); end
    tx.rx_busy = 1'b0;
    repeat (3) tick();
    total++; if (n_start - s_start !== 0) begin bad++; $display("FAIL rx_start_count got=%0d want=0", n_start - s_start); end
  endtask

  task automatic test_reset_mid();
    int s_succ = n_succ, s_fail = n_fail, s_disc = n_disc, s_abort = n_abort;
    drive_wr(8'h03);
    tick();
    tick();
    #2;
    reset_L = 1'b0;
    #1;
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", tx.busy); end
    total++; if (tx.msg_sop_type !== 3'b000) begin bad++; $display("FAIL rm_type got=%b want=000", tx.msg_sop_type); end
    total++; if (tx.msg_start !== 1'b0 || tx.msg_abort !== 1'b0) begin bad++; $display("FAIL rm_msg got=%b%b want=00", tx.msg_start, tx.msg_abort); end
    total++; if (tx.hr_hard_reset_L !== 1'b1 || tx.hr_cable_reset_L !== 1'b1) begin bad++; $display("FAIL rm_hr got=%b%b want=11", tx.hr_hard_reset_L, tx.hr_cable_reset_L); end
    repeat (3) tick();
    reset_L = 1'b1;
    repeat (20) tick();
    total++; if (n_succ + n_fail + n_disc - s_succ - s_fail - s_disc !== 0) begin bad++; $display("FAIL rm_alerts got=%0d want=0", n_succ + n_fail + n_disc - s_succ - s_fail - s_disc); end
    total++; if (n_abort - s_abort !== 0) begin bad++; $display("FAIL rm_abort_count got=%0d want=0", n_abort - s_abort); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL rm_busy_after got=%b want=0", tx.busy); end
  endtask

  task automatic test_back_to_back();
    drive_wr(8'h00);
    tick();
    pulse_done(1'b1);
    total++; if (tx.ALERT_TransmitSuccessful !== 1'b1) begin bad++; $display("FAIL bb_succ1 got=%b want=1", tx.ALERT_TransmitSuccessful); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL bb_busy1 got=%b want=0", tx.busy); end
    drive_wr(8'h07);
    total++; if (tx.msg_start !== 1'b1) begin bad++; $display("FAIL bb_start2 got=%b want=1", tx.msg_start); end
    total++; if (tx.msg_sop_type !== 3'b111) begin bad++; $display("FAIL bb_type2 got=%b want=111", tx.msg_sop_type); end
    tick();
    drive_wr(8'h02);
    total++; if (tx.ALERT_TransmitSOPMessageDiscarded !== 1'b1) begin bad++; $display("FAIL bb_disc got=%b want=1", tx.ALERT_TransmitSOPMessageDiscarded); end
    total++; if (tx.msg_sop_type !== 3'b111) begin bad++; $display("FAIL bb_type_hold got=%b want=111", tx.msg_sop_type); end
    pulse_done(1'b0);
    total++; if (tx.ALERT_TransmitSuccessful !== 1'b1) begin bad++; $display("FAIL bb_bist_succ got=%b want=1", tx.ALERT_TransmitSuccessful); end
    total++; if (tx.msg_start !== 1'b0) begin bad++; $display("FAIL bb_bist_noretry got=%b want=0", tx.msg_start); end
    total++; if (tx.busy !== 1'b0) begin bad++; $display("FAIL bb_busy2 got=%b want=0", tx.busy); end
    tick();
  endtask

  initial begin
    tx.transmit_wr = 1'b0;
    tx.TRANSMIT    = 8'h00;
    tx.rx_busy     = 1'b0;
    tx.msg_done    = 1'b0;
    tx.msg_goodcrc = 1'b0;
    tx.hr_success  = 1'b0;
    tx.hr_failed   = 1'b0;
    test_reset();
    test_retry_success();
    test_retry_fail();
    test_watchdog();
    test_preempt();
    test_cable_fail();
    test_rx_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
